mem_port_arbiter: RTL and testbench

- Round-robin arbiter that shares one SRAM-like memory port (addr_ok/data_ok handshake, one outstanding transaction) between NUM_REQ requesters, e.g. instruction fetch, data load/store, cache refill.
- Produces a registered binary select that drives the external Mux4T1-style selector for the address, wdata, wr and size buses.
- Routes the port's addr_ok/data_ok back to the granted requester only.
- Sits between the pipeline memory stages and the AXI bridge.

---
 rtl/mem_port_arbiter.sv | 108 ++++++++++
 tb/tb_mem_port_arbiter.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Round-robin owner of one addr_ok/data_ok memory port shared by NUM_REQ requesters.
// Registered select drives the external bus mux; handshakes are routed back to the owner.
module mem_port_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int SEL_W   = 2,
    parameter int TIMEOUT = 256,
    parameter int CNT_W   = 8
) (
    input  logic               aclk,
    input  logic               aresetn,
    input  logic [NUM_REQ-1:0] req,
    output logic [SEL_W-1:0]   sel,
    output logic               bus_req,
    input  logic               bus_addr_ok,
    input  logic               bus_data_ok,
    output logic [NUM_REQ-1:0] gnt_addr_ok,
    output logic [NUM_REQ-1:0] gnt_data_ok,
    output logic               busy,
    output logic               timeout_err
);

    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

    state_t             state;
    logic [SEL_W-1:0]   ptr;
    logic [SEL_W-1:0]   win;
    logic [SEL_W-1:0]   ptr_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [NUM_REQ-1:0] sel_oh;
    logic               any_req;
    logic               req_sel;
    logic               cnt_last;

    // First set request bit at or after ptr, wrapping modulo NUM_REQ.
    always_comb begin
        int j;
        win     = ptr;
        any_req = 1'b0;
        j       = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            j = int'(ptr) + i;
            if (j >= NUM_REQ) j = j - NUM_REQ;
            if (!any_req && req[j]) begin
                any_req = 1'b1;
                win     = SEL_W'(j);
            end
        end
    end

    always_comb begin
        sel_oh = '0;
        for (int i = 0; i < NUM_REQ; i++)
            sel_oh[i] = (sel == SEL_W'(i));
    end

    assign req_sel  = |(req & sel_oh);
    assign ptr_nxt  = (sel == SEL_W'(NUM_REQ - 1)) ? '0 : sel + SEL_W'(1);
    assign cnt_last = (cnt == CNT_W'(TIMEOUT - 1));

    assign busy        = (state != IDLE);
    assign bus_req     = (state == ADDR);
    assign gnt_addr_ok = (state == ADDR && bus_addr_ok) ? sel_oh : '0;
    assign gnt_data_ok = (state == DATA && bus_data_ok) ? sel_oh : '0;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state       <= IDLE;
            sel         <= '0;
            ptr         <= '0;
            cnt         <= '0;
            timeout_err <= 1'b0;
        end else begin
            timeout_err <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus_data_ok) timeout_err <= 1'b1;
                    if (any_req) begin
                        sel   <= win;
                        state <= ADDR;
                    end
                end
                ADDR: begin
                    if (bus_data_ok) timeout_err <= 1'b1;
                    if (bus_addr_ok) begin
                        state <= DATA;
                        cnt   <= '0;
                    end else if (!req_sel) begin
                        state <= IDLE;
                    end
                end
                DATA: begin
                    if (bus_data_ok) begin
                        ptr   <= ptr_nxt;
                        state <= IDLE;
                    end else if (cnt_last) begin
                        timeout_err <= 1'b1;
                        ptr         <= ptr_nxt;
                        state       <= IDLE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: grant order, handshake routing,
// timeout, withdraw, spurious events and async reset.
module tb_mem_port_arbiter;

    logic       aclk = 1'b0;
    logic       aresetn;
    logic [3:0] req;
    logic [1:0] sel;
    logic       bus_req;
    logic       bus_addr_ok;
    logic       bus_data_ok;
    logic [3:0] gnt_addr_ok;
    logic [3:0] gnt_data_ok;
    logic       busy;
    logic       timeout_err;

    int n_cmp = 0;
    int n_bad = 0;

    mem_port_arbiter #(
        .NUM_REQ(4), .SEL_W(2), .TIMEOUT(8), .CNT_W(8)
    ) dut (
        .aclk(aclk), .aresetn(aresetn), .req(req), .sel(sel),
        .bus_req(bus_req), .bus_addr_ok(bus_addr_ok),
        .bus_data_ok(bus_data_ok), .gnt_addr_ok(gnt_addr_ok),
        .gnt_data_ok(gnt_data_ok), .busy(busy),
        .timeout_err(timeout_err)
    );

    always #5 aclk = ~aclk;

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    task automatic do_reset();
        aresetn = 1'b0;
        step();
        step();
        aresetn = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        aresetn = 1'b0; req = '0; bus_addr_ok = 1'b0; bus_data_ok = 1'b0;
        #1;
        n_cmp++; if (sel !== 2'd0) begin n_bad++; $display("FAIL rst_sel got %0d want 0", sel); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy got %b want 0", busy); end
        n_cmp++; if (bus_req !== 1'b0) begin n_bad++; $display("FAIL rst_bus_req got %b want 0", bus_req); end
        n_cmp++; if (timeout_err !== 1'b0) begin n_bad++; $display("FAIL rst_terr got %b want 0", timeout_err); end
        n_cmp++; if ({gnt_addr_ok, gnt_data_ok} !== 8'h00) begin n_bad++; $display("FAIL rst_gnt got %h want 00", {gnt_addr_ok, gnt_data_ok}); end
        step();
        aresetn = 1'b1;
        #1;
    endtask

    task automatic test_single();
        req = 4'b0100;
        step();
        n_cmp++; if (sel !== 2'd2) begin n_bad++; $display("FAIL single_sel got %0d want 2", sel); end
        n_cmp++; if (bus_req !== 1'b1) begin n_bad++; $display("FAIL single_bus_req got %b want 1", bus_req); end
        step();
        n_cmp++; if (gnt_addr_ok !== 4'b0000) begin n_bad++; $display("FAIL single_early_gnt got %b want 0000", gnt_addr_ok); end
        step();
        bus_addr_ok = 1'b1;
        #1;
        n_cmp++; if (gnt_addr_ok !== 4'b0100) begin n_bad++; $display("FAIL single_gnt_addr got %b want 0100", gnt_addr_ok); end
        step();
        bus_addr_ok = 1'b0; req = '0;
        #1;
        n_cmp++; if (gnt_data_ok !== 4'b0000) begin n_bad++; $display("FAIL single_data_wait got %b want 0000", gnt_data_ok); end
        n_cmp++; if (bus_req !== 1'b0) begin n_bad++; $display("FAIL single_data_breq got %b want 0", bus_req); end
        step();
        step();
        bus_data_ok = 1'b1;
        #1;
        n_cmp++; if (gnt_data_ok !== 4'b0100) begin n_bad++; $display("FAIL single_gnt_data got %b want 0100", gnt_data_ok); end
        n_cmp++; if (sel !== 2'd2) begin n_bad++; $display("FAIL single_sel_hold got %0d want 2", sel); end
        step();
        bus_data_ok = 1'b0;
        #1;
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL single_busy got %b want 0", busy); end
        n_cmp++; if (dut.ptr !== 2'd3) begin n_bad++; $display("FAIL single_ptr got %0d want 3", dut.ptr); end
        n_cmp++; if (timeout_err !== 1'b0) begin n_bad++; $display("FAIL single_terr got %b want 0", timeout_err); end
    endtask

    // Three-cycle transaction: IDLE, ADDR with addr_ok, DATA with data_ok.
    task automatic run_txn(input logic [3:0] r, input logic [1:0] exp, input string tag);
        logic [3:0] oh;
        oh = 4'b0001 << exp;
        req = r;
        #1;
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL %s_idle got busy=%b want 0", tag, busy); end
        step();
        n_cmp++; if (sel !== exp) begin n_bad++; $display("FAIL %s_sel got %0d want %0d", tag, sel, exp); end
        bus_addr_ok = 1'b1;
        #1;
        n_cmp++; if (gnt_addr_ok !== oh) begin n_bad++; $display("FAIL %s_gnt_addr got %b want %b", tag, gnt_addr_ok, oh); end
        step();
        bus_addr_ok = 1'b0; bus_data_ok = 1'b1;
        #1;
        n_cmp++; if (gnt_data_ok !== oh) begin n_bad++; $display("FAIL %s_gnt_data got %b want %b", tag, gnt_data_ok, oh); end
        step();
        bus_data_ok = 1'b0;
        #1;
        n_cmp++; if (timeout_err !== 1'b0) begin n_bad++; $display("FAIL %s_terr got %b want 0", tag, timeout_err); end
    endtask

    task automatic test_round_robin();
        logic [1:0] order [5];
        order = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        do_reset();
        for (int k = 0; k < 5; k++)
            run_txn(4'b1111, order[k], $sformatf("rr%0d", k));
        req = '0;
    endtask

    task automatic test_wrap();
        run_txn(4'b0100, 2'd2, "wrap_pre");
        req = '0;
        #1;
        n_cmp++; if (dut.ptr !== 2'd3) begin n_bad++; $display("FAIL wrap_ptr3 got %0d want 3", dut.ptr); end
        run_txn(4'b1001, 2'd3, "wrap_a");
        n_cmp++; if (dut.ptr !== 2'd0) begin n_bad++; $display("FAIL wrap_ptr0 got %0d want 0", dut.ptr); end
        run_txn(4'b1001, 2'd0, "wrap_b");
        req = '0;
    endtask

    task automatic test_timeout();
        req = 4'b0010;
        step();
        n_cmp++; if (sel !== 2'd1) begin n_bad++; $display("FAIL to_sel got %0d want 1", sel); end
        bus_addr_ok = 1'b1;
        step();
        bus_addr_ok = 1'b0; req = '0;
        for (int n = 1; n <= 9; n++) begin
            step();
            if (n < 8) begin
                n_cmp++; if ({busy, timeout_err} !== 2'b10) begin n_bad++; $display("FAIL to_wait%0d got busy/terr=%b want 10", n, {busy, timeout_err}); end
            end else if (n == 8) begin
                n_cmp++; if ({busy, timeout_err} !== 2'b01) begin n_bad++; $display("FAIL to_fire got busy/terr=%b want 01", {busy, timeout_err}); end
                n_cmp++; if (dut.ptr !== 2'd2) begin n_bad++; $display("FAIL to_ptr got %0d want 2", dut.ptr); end
            end else begin
                n_cmp++; if (timeout_err !== 1'b0) begin n_bad++; $display("FAIL to_pulse_len got %b want 0", timeout_err); end
            end
        end
    endtask

    task automatic test_withdraw_spurious();
        do_reset();
        req = 4'b0001;
        step();
        n_cmp++; if ({bus_req, sel} !== 3'b100) begin n_bad++; $display("FAIL wd_addr got breq/sel=%b want 100", {bus_req, sel}); end
        req = '0;
        #1;
        n_cmp++; if (gnt_addr_ok !== 4'b0000) begin n_bad++; $display("FAIL wd_gnt got %b want 0000", gnt_addr_ok); end
        step();
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL wd_busy got %b want 0", busy); end
        n_cmp++; if (dut.ptr !== 2'd0) begin n_bad++; $display("FAIL wd_ptr got %0d want 0", dut.ptr); end
        bus_addr_ok = 1'b1;
        #1;
        n_cmp++; if (gnt_addr_ok !== 4'b0000) begin n_bad++; $display("FAIL sp_addr_gnt got %b want 0000", gnt_addr_ok); end
        bus_addr_ok = 1'b0; bus_data_ok = 1'b1;
        #1;
        n_cmp++; if (gnt_data_ok !== 4'b0000) begin n_bad++; $display("FAIL sp_data_gnt got %b want 0000", gnt_data_ok); end
        step();
        bus_data_ok = 1'b0;
        #1;
        n_cmp++; if ({busy, timeout_err} !== 2'b01) begin n_bad++; $display("FAIL sp_terr got busy/terr=%b want 01", {busy, timeout_err}); end
        step();
        n_cmp++; if (timeout_err !== 1'b0) begin n_bad++; $display("FAIL sp_pulse_len got %b want 0", timeout_err); end
    endtask

    task automatic test_async_reset();
        req = 4'b1000;
        step();
        bus_addr_ok = 1'b1;
        step();
        bus_addr_ok = 1'b0; req = '0;
        #1;
        n_cmp++; if ({busy, sel} !== 3'b111) begin n_bad++; $display("FAIL ar_data got busy/sel=%b want 111", {busy, sel}); end
        #1;
        aresetn = 1'b0; bus_data_ok = 1'b1;
        #1;
        n_cmp++; if ({busy, bus_req, sel} !== 4'b0000) begin n_bad++; $display("FAIL ar_now got busy/breq/sel=%b want 0000", {busy, bus_req, sel}); end
        n_cmp++; if (gnt_data_ok !== 4'b0000) begin n_bad++; $display("FAIL ar_gnt got %b want 0000", gnt_data_ok); end
        bus_data_ok = 1'b0;
        step();
        aresetn = 1'b1; req = 4'b1000;
        #1;
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL ar_idle got %b want 0", busy); end
        step();
        n_cmp++; if ({bus_req, sel} !== 3'b111) begin n_bad++; $display("FAIL ar_regrant got breq/sel=%b want 111", {bus_req, sel}); end
        n_cmp++; if (dut.ptr !== 2'd0) begin n_bad++; $display("FAIL ar_ptr got %0d want 0", dut.ptr); end
        req = '0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_wrap();
        test_timeout();
        test_withdraw_spurious();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
